// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: fetches sequential 16-bit words into a small queue and issues them in order.
// Optional macro FETCH_BUFFER_BYPASS_EN forwards a completion straight to the issue port when the queue is empty.
module fetch_buffer #(
    parameter int          Depth       = 4,
    parameter logic [15:0] ResetVector = 16'h0000
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic [15:0] InstructionAddress,
    output logic        FetchRequest,
    input  logic        InstructionReady,
    input  logic [15:0] Instruction,
    output logic        IssueValid,
    output logic [15:0] IssueWord,
    output logic [15:0] IssuePC,
    input  logic        IssueAccept,
    input  logic        Redirect,
    input  logic [15:0] RedirectTarget
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

    logic [15:0]     fetchPc_r;
    logic [PtrW-1:0] rdPtr_r;
    logic [PtrW-1:0] wrPtr_r;
    logic [CntW-1:0] count_r;
    logic [15:0]     wordMem_r [Depth];
    logic [15:0]     pcMem_r   [Depth];

    logic queueEmpty_s;
    logic complete_s;
    logic push_s;
    logic pop_s;
`ifdef FETCH_BUFFER_BYPASS_EN
    logic bypassHit_s;
`endif

    // Fetch handshake, queue push/pop decisions and issue-port selection.
    always_comb begin
        queueEmpty_s       = (count_r == {CntW{1'b0}});
        FetchRequest       = !Reset && !Redirect && (count_r < DepthCnt);
        InstructionAddress = fetchPc_r;
        complete_s         = FetchRequest && InstructionReady;
        // The queue only pops when it holds something; a bypassed word never occupies an entry.
        pop_s              = !Reset && !Redirect && !queueEmpty_s && IssueAccept;
`ifdef FETCH_BUFFER_BYPASS_EN
        bypassHit_s = complete_s && queueEmpty_s;
        push_s      = complete_s && !(bypassHit_s && IssueAccept);
        if (bypassHit_s) begin
            IssueValid = 1'b1;
            IssueWord  = Instruction;
            IssuePC    = fetchPc_r;
        end else begin
            IssueValid = !queueEmpty_s;
            IssueWord  = wordMem_r[rdPtr_r];
            IssuePC    = pcMem_r[rdPtr_r];
        end
`else
        push_s     = complete_s;
        IssueValid = !queueEmpty_s;
        IssueWord  = wordMem_r[rdPtr_r];
        IssuePC    = pcMem_r[rdPtr_r];
`endif
    end

    // Fetch PC, queue pointers and occupancy; reset beats redirect, redirect beats traffic.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            fetchPc_r <= ResetVector;
            rdPtr_r   <= {PtrW{1'b0}};
            wrPtr_r   <= {PtrW{1'b0}};
            count_r   <= {CntW{1'b0}};
        end else if (Redirect) begin
            fetchPc_r <= RedirectTarget & 16'hFFFE;
            rdPtr_r   <= {PtrW{1'b0}};
            wrPtr_r   <= {PtrW{1'b0}};
            count_r   <= {CntW{1'b0}};
        end else begin
            // PC advances on every completion, including one consumed through the bypass.
            if (complete_s) begin
                fetchPc_r <= fetchPc_r + 16'h0002;
            end else begin
                fetchPc_r <= fetchPc_r;
            end
            if (push_s) begin
                wrPtr_r <= wrPtr_r + PtrW'(1);
            end else begin
                wrPtr_r <= wrPtr_r;
            end
            if (pop_s) begin
                rdPtr_r <= rdPtr_r + PtrW'(1);
            end else begin
                rdPtr_r <= rdPtr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CntW'(1);
                2'b01:   count_r <= count_r - CntW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Queue storage; contents are don't-care until written, so no reset here.
    always_ff @(posedge Clock) begin
        if (push_s) begin
            wordMem_r[wrPtr_r] <= Instruction;
            pcMem_r[wrPtr_r]   <= fetchPc_r;
        end else begin
            wordMem_r[wrPtr_r] <= wordMem_r[wrPtr_r];
            pcMem_r[wrPtr_r]   <= pcMem_r[wrPtr_r];
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: queue-based reference model compared every cycle,
// plus hand-computed literal checks for reset, full queue, redirect, wrap and empty-queue completion.
module tb_fetch_buffer;

    localparam int          DEPTH = 4;
    localparam logic [15:0] RV    = 16'h0100;

    logic        Clock;
    logic        Reset;
    logic [15:0] InstructionAddress;
    logic        FetchRequest;
    logic        InstructionReady;
    logic [15:0] Instruction;
    logic        IssueValid;
    logic [15:0] IssueWord;
    logic [15:0] IssuePC;
    logic        IssueAccept;
    logic        Redirect;
    logic [15:0] RedirectTarget;

    logic        useOverride;
    logic [15:0] overrideWord;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] w;
    } ent_t;

    ent_t        q[$];
    logic [15:0] modelPc;
    int          total;
    int          bad;
    int          issuedCount;

    fetch_buffer #(.Depth(DEPTH), .ResetVector(RV)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .InstructionAddress(InstructionAddress),
        .FetchRequest(FetchRequest),
        .InstructionReady(InstructionReady),
        .Instruction(Instruction),
        .IssueValid(IssueValid),
        .IssueWord(IssueWord),
        .IssuePC(IssuePC),
        .IssueAccept(IssueAccept),
        .Redirect(Redirect),
        .RedirectTarget(RedirectTarget)
    );

    function automatic logic [15:0] memWord(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    // Instruction memory model: word is a fixed scramble of the address unless overridden.
    assign Instruction = useOverride ? overrideWord : memWord(InstructionAddress);

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: apply inputs, compare outputs against the model, then advance the model at the edge.
    task automatic cycle(input logic rst, input logic rdy, input logic acc,
                         input logic rdr, input logic [15:0] tgt);
        logic        expFr;
        logic        expValid;
        logic [15:0] expWord;
        logic [15:0] expPc;
        logic [15:0] instrNow;
        logic        fire;
        logic        pop;
        logic        bypassUsed;
        Reset            = rst;
        InstructionReady = rdy;
        IssueAccept      = acc;
        Redirect         = rdr;
        RedirectTarget   = tgt;
        #1;
        expFr      = !rst && !rdr && (q.size() < DEPTH);
        instrNow   = useOverride ? overrideWord : memWord(modelPc);
        expValid   = (q.size() != 0);
        expWord    = expValid ? q[0].w  : 16'h0000;
        expPc      = expValid ? q[0].pc : 16'h0000;
        fire       = expFr && rdy;
        bypassUsed = 1'b0;
`ifdef FETCH_BUFFER_BYPASS_EN
        if (fire && q.size() == 0) begin
            expValid   = 1'b1;
            expWord    = instrNow;
            expPc      = modelPc;
            bypassUsed = acc;
        end
`endif
        pop = !rst && !rdr && acc && (q.size() != 0);
        chk("fetch_request", {15'd0, FetchRequest}, {15'd0, expFr});
        if (!rst) begin
            chk("instr_addr", InstructionAddress, modelPc);
            chk("issue_valid", {15'd0, IssueValid}, {15'd0, expValid});
            if (expValid) begin
                chk("issue_word", IssueWord, expWord);
                chk("issue_pc", IssuePC, expPc);
            end
        end
        if (!rst && !rdr && acc && expValid) issuedCount++;
        @(posedge Clock);
        if (rst) begin
            q.delete();
            modelPc = RV;
        end else if (rdr) begin
            q.delete();
            modelPc = tgt & 16'hFFFE;
        end else begin
            if (pop) void'(q.pop_front());
            if (fire) begin
                if (!bypassUsed) q.push_back('{pc: modelPc, w: instrNow});
                modelPc = modelPc + 16'h0002;
            end
        end
        @(negedge Clock);
        Reset    = 1'b0;
        Redirect = 1'b0;
        #1;
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        issuedCount      = 0;
        Reset            = 1'b1;
        InstructionReady = 1'b0;
        IssueAccept      = 1'b0;
        Redirect         = 1'b0;
        RedirectTarget   = 16'h0000;
        useOverride      = 1'b0;
        overrideWord     = 16'h0000;
        modelPc          = RV;
        @(negedge Clock);

        // Reset, with redirect and accept active to show reset wins.
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 16'h5555);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk("post_reset_fr", {15'd0, FetchRequest}, 16'h0001);
        chk("post_reset_addr", InstructionAddress, 16'h0100);
        chk("post_reset_valid", {15'd0, IssueValid}, 16'h0000);

        // Fill the queue from the reset vector.
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("full_issue_pc", IssuePC, 16'h0100);
        chk("full_fr", {15'd0, FetchRequest}, 16'h0000);
        chk("full_addr", InstructionAddress, 16'h0108);
        chk("full_word", IssueWord, memWord(16'h0100));

        // One accept frees a slot.
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        chk("pop_issue_pc", IssuePC, 16'h0102);
        chk("pop_fr", {15'd0, FetchRequest}, 16'h0001);
        chk("pop_addr", InstructionAddress, 16'h0108);

        // Redirect with ready and accept asserted.
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 16'h2001);
        chk("redir_valid", {15'd0, IssueValid}, 16'h0000);
        chk("redir_addr", InstructionAddress, 16'h2000);
        chk("redir_fr", {15'd0, FetchRequest}, 16'h0001);

        // Held redirect: last target wins.
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 16'h3000);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h4003);
        chk("held_redir_addr", InstructionAddress, 16'h4002);

        // Fetch PC wrap.
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF);
        chk("wrap_start_addr", InstructionAddress, 16'hFFFE);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("wrap_addr", InstructionAddress, 16'h0000);
        chk("wrap_pc0", IssuePC, 16'hFFFE);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        chk("wrap_pc1", IssuePC, 16'h0000);

        // Completion into an empty queue.
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h0200);
        useOverride  = 1'b1;
        overrideWord = 16'hABCD;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        useOverride  = 1'b0;
        chk("empty_valid", {15'd0, IssueValid}, 16'h0001);
        chk("empty_word", IssueWord, 16'hABCD);
        chk("empty_pc", IssuePC, 16'h0200);

        // Random traffic: ready ~30%, accept ~50%, rare redirects.
        for (int i = 0; i < 1000; i++) begin
            logic rdy;
            logic acc;
            logic rdr;
            rdy = ($urandom_range(0, 99) < 30);
            acc = ($urandom_range(0, 99) < 50);
            rdr = ($urandom_range(0, 99) < 2);
            cycle(1'b0, rdy, acc, rdr, 16'($urandom));
        end

        // Drain with accept only; queue must empty.
        Reset = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        chk("drain_valid", {15'd0, IssueValid}, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
